// File: rtl/bp_fe_bp_gselect_pkg.sv
// Shared types and helpers for the gselect front-end controller.
// The widths here must match the parameters the controller is built with.
package bp_fe_bp_gselect_pkg;

   localparam int BHT_IDX_W = 9;
   localparam int GHIST_W   = 4;
   localparam int PC_W      = 32;

   typedef struct packed {
      logic [BHT_IDX_W-1:0] idx;
      logic                 pred;
      logic [GHIST_W-1:0]   ghr;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOOKUP = 1'b1
   } state_t;

   function automatic logic [BHT_IDX_W-1:0] form_idx(input logic [PC_W-1:0]    pc,
                                                     input logic [GHIST_W-1:0] ghr);
      return {pc[BHT_IDX_W-GHIST_W+1:2], ghr};
   endfunction

   function automatic logic [GHIST_W-1:0] ghr_shift(input logic [GHIST_W-1:0] ghr,
                                                    input logic               dir);
      return {ghr[GHIST_W-2:0], dir};
   endfunction

endpackage

// File: rtl/bp_fe_bp_inflight_fifo.sv
// In-order queue of in-flight branches with a synchronous clear input.
// Latency: enqueued data is visible at the head one cycle later.
// Backpressure: enqueue is dropped when full unless a dequeue happens in the same cycle.
module bp_fe_bp_inflight_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clr,
   input  logic                   i_enq,
   input  logic [WIDTH-1:0]       i_enq_dat,
   input  logic                   i_deq,
   output logic [WIDTH-1:0]       o_head_dat,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;
   logic             w_enq;
   logic             w_deq;

   assign o_full     = (r_count == CNT_W'(DEPTH));
   assign o_empty    = (r_count == '0);
   assign o_count    = r_count;
   assign o_head_dat = r_mem[r_rptr];
   assign w_deq      = i_deq & ~o_empty;
   assign w_enq      = i_enq & (~o_full | w_deq);

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_enq) r_wptr <= r_wptr + PTR_W'(1);
         if (w_deq) r_rptr <= r_rptr + PTR_W'(1);
         r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_enq & ~i_clr) r_mem[r_wptr] <= i_enq_dat;
   end

endmodule

// File: rtl/bp_fe_bp_gselect_ctrl.sv
// Gselect read/update controller: speculative GHR, in-flight queue, mispredict repair (stats: BP_GSELECT_CTRL_STATS_EN).
// Latency: index same cycle, prediction next cycle; update/flush registered one cycle after resolve.
// Backpressure: fetch_ready_o low during LOOKUP or when the in-flight queue is full.
module bp_fe_bp_gselect_ctrl
   import bp_fe_bp_gselect_pkg::*;
#(
   parameter int bht_idx_width_p = 9,
   parameter int ghist_width_p   = 4,
   parameter int pc_width_p      = 32,
   parameter int fifo_els_p      = 8
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       fetch_v_i,
   input  logic [pc_width_p-1:0]      fetch_pc_i,
   output logic                       fetch_ready_o,
   output logic                       pred_v_o,
   output logic                       pred_taken_o,
   output logic                       r_v_o,
   output logic [bht_idx_width_p-1:0] idx_r_o,
   input  logic                       predict_i,
   input  logic                       resolve_v_i,
   input  logic                       resolve_taken_i,
   output logic                       flush_o,
   output logic                       w_v_o,
   output logic [bht_idx_width_p-1:0] idx_w_o,
   output logic                       correct_o,
   output logic                       err_resolve_empty_o
`ifdef BP_GSELECT_CTRL_STATS_EN
   ,
   output logic [31:0]                stat_branches_o,
   output logic [31:0]                stat_mispredicts_o
`endif
);

   localparam int CNT_W = $clog2(fifo_els_p) + 1;

   state_t                     r_state;
   logic [ghist_width_p-1:0]   r_ghr;
   logic [bht_idx_width_p-1:0] r_idx;
   logic                       r_w_v;
   logic [bht_idx_width_p-1:0] r_idx_w;
   logic                       r_correct;
   logic                       r_flush;
   logic                       r_err;

   entry_t                     w_head;
   entry_t                     w_enq_dat;
   logic [ENTRY_W-1:0]         w_head_raw;
   logic                       w_full;
   logic                       w_empty;
   logic [CNT_W-1:0]           w_count;
   logic                       w_accept;
   logic                       w_lookup;
   logic                       w_resolve;
   logic                       w_correct;
   logic                       w_mispred;
   logic                       w_enq;

   assign w_lookup      = (r_state == ST_LOOKUP);
   assign fetch_ready_o = (r_state == ST_IDLE) & ~w_full;
   assign w_accept      = fetch_v_i & fetch_ready_o;
   assign r_v_o         = w_accept;
   assign idx_r_o       = form_idx(fetch_pc_i, r_ghr);

   assign w_head    = entry_t'(w_head_raw);
   assign w_resolve = resolve_v_i & (w_count != '0);
   assign w_correct = (w_head.pred == resolve_taken_i);
   assign w_mispred = w_resolve & ~w_correct;

   // A mispredict in the LOOKUP cycle kills the lookup: it was indexed with wrong-path history.
   assign w_enq         = w_lookup & ~w_mispred;
   assign pred_v_o      = w_enq;
   assign pred_taken_o  = w_enq & predict_i;
   assign w_enq_dat.idx  = r_idx;
   assign w_enq_dat.pred = predict_i;
   assign w_enq_dat.ghr  = r_ghr;

   bp_fe_bp_inflight_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (fifo_els_p)
   ) u_inflight (
      .i_clk      (clk_i),
      .i_rst      (reset_i),
      .i_clr      (w_mispred),
      .i_enq      (w_enq),
      .i_enq_dat  (w_enq_dat),
      .i_deq      (w_resolve),
      .o_head_dat (w_head_raw),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state   <= ST_IDLE;
         r_ghr     <= '0;
         r_idx     <= '0;
         r_w_v     <= 1'b0;
         r_idx_w   <= '0;
         r_correct <= 1'b0;
         r_flush   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE:   if (w_accept) r_state <= ST_LOOKUP;
            ST_LOOKUP: r_state <= ST_IDLE;
            default:   r_state <= ST_IDLE;
         endcase
         if (w_accept) r_idx <= idx_r_o;
         // Repair restarts history from the mispredicted branch's own snapshot.
         if (w_mispred)  r_ghr <= ghr_shift(w_head.ghr, resolve_taken_i);
         else if (w_enq) r_ghr <= ghr_shift(r_ghr, predict_i);
         r_w_v   <= w_resolve;
         r_flush <= w_mispred;
         if (w_resolve) begin
            r_idx_w   <= w_head.idx;
            r_correct <= w_correct;
         end
         if (resolve_v_i & w_empty) r_err <= 1'b1;
      end
   end

   assign w_v_o               = r_w_v;
   assign idx_w_o             = r_idx_w;
   assign correct_o           = r_correct;
   assign flush_o             = r_flush;
   assign err_resolve_empty_o = r_err;

`ifdef BP_GSELECT_CTRL_STATS_EN
   logic [31:0] r_stat_br;
   logic [31:0] r_stat_mp;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_stat_br <= '0;
         r_stat_mp <= '0;
      end else if (r_w_v) begin
         if (r_stat_br != '1) r_stat_br <= r_stat_br + 32'd1;
         if (~r_correct && (r_stat_mp != '1)) r_stat_mp <= r_stat_mp + 32'd1;
      end
   end

   assign stat_branches_o    = r_stat_br;
   assign stat_mispredicts_o = r_stat_mp;
`endif

endmodule
